// File: rtl/aes_iter_cipher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_iter_cipher                                                            |
// | Iterative AES-128/192/256 encrypt/decrypt core, one round per clock,       |
// | with a cached round-key schedule expanded one word per cycle at key load.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module aes_iter_cipher #(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NK*32-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  output logic             key_loaded,
  input  logic [127:0]     in_data,
  input  logic             in_dec,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [127:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_KEYEXP = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_iter_cipher: NK must be 4, 6 or 8");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128 (0 maps to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte 4*c+r of the state sits at bit 127-8*(4*c+r) (FIPS-197 ordering).
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = isbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      if (inv)
        o[127-32*c -: 32] = {
          gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
          gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
          gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
          gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
      else
        o[127-32*c -: 32] = {
          xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
          a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
          a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
          xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  logic [1:0]   r_state, w_next_state;
  logic [31:0]  r_rk [NW];
  logic [5:0]   r_widx;
  logic [2:0]   r_kmod;
  logic [7:0]   r_rcon;
  logic [127:0] r_st;
  logic [3:0]   r_round;
  logic         r_dec;
  logic [31:0]  w_ktmp, w_kword;
  logic [3:0]   w_rk_idx;
  logic [127:0] w_rk, w_round;
  logic         w_key_hs, w_in_hs, w_last, w_kexp_last;

  assign w_key_hs    = key_valid && key_ready;
  assign w_in_hs     = in_valid && in_ready;
  assign w_last      = (r_round == 4'(NR));
  assign w_kexp_last = (r_widx == 6'(NW - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_key_hs)     w_next_state = S_KEYEXP;
        else if (w_in_hs) w_next_state = S_RUN;
      end
      S_KEYEXP: if (w_kexp_last) w_next_state = S_IDLE;
      S_RUN:    if (w_last)      w_next_state = S_DONE;
      S_DONE:   if (out_ready)   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    key_ready = (r_state == S_IDLE) && rst_n;
    in_ready  = (r_state == S_IDLE) && key_loaded && !key_valid && rst_n;
    busy      = (r_state != S_IDLE);
  end

  always_comb begin
    w_ktmp = r_rk[r_widx - 6'd1];
    if (r_kmod == 3'd0)
      w_ktmp = sub_word({w_ktmp[23:0], w_ktmp[31:24]}) ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_kmod == 3'd4)
      w_ktmp = sub_word(w_ktmp);
    w_kword = r_rk[r_widx - 6'(NK)] ^ w_ktmp;
  end

  // The schedule itself needs no reset: key_loaded guards its validity.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_key_hs) begin
        for (int i = 0; i < NK; i++) r_rk[i] <= key_in[(NK-1-i)*32 +: 32];
        r_widx <= 6'(NK);
        r_kmod <= 3'd0;
        r_rcon <= 8'h01;
      end else if (r_state == S_KEYEXP) begin
        r_rk[r_widx] <= w_kword;
        r_widx       <= r_widx + 6'd1;
        r_kmod       <= (r_kmod == 3'(NK - 1)) ? 3'd0 : r_kmod + 3'd1;
        if (r_kmod == 3'd0) r_rcon <= xt(r_rcon);
      end
    end
  end

  // In IDLE the mux presents the whitening key for the block being offered.
  always_comb begin
    if (r_state == S_IDLE) w_rk_idx = in_dec ? 4'(NR) : 4'd0;
    else                   w_rk_idx = r_dec ? 4'(NR) - r_round : r_round;
  end
  assign w_rk = {r_rk[{w_rk_idx, 2'd0}], r_rk[{w_rk_idx, 2'd1}],
                 r_rk[{w_rk_idx, 2'd2}], r_rk[{w_rk_idx, 2'd3}]};

  always_comb begin
    if (r_dec) begin
      w_round = inv_sub_shift(r_st) ^ w_rk;
      if (!w_last) w_round = mix(w_round, 1'b1);
    end else begin
      w_round = sub_shift(r_st);
      if (!w_last) w_round = mix(w_round, 1'b0);
      w_round = w_round ^ w_rk;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st       <= '0;
      r_round    <= 4'd0;
      r_dec      <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      key_loaded <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_key_hs) begin
            key_loaded <= 1'b0;
          end else if (w_in_hs) begin
            r_dec   <= in_dec;
            r_st    <= in_data ^ w_rk;
            r_round <= 4'd1;
          end
        end
        S_KEYEXP: if (w_kexp_last) key_loaded <= 1'b1;
        S_RUN: begin
          r_st    <= w_round;
          r_round <= r_round + 4'd1;
          if (w_last) begin
            out_data  <= w_round;
            out_valid <= 1'b1;
          end
        end
        S_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
